// File: rtl/pkt_pingpong_ctrl_if.sv
// Handshake and FIFO-control bundle between the packet source, the two
// ping-pong FIFOs, the read sequencer and pkt_pingpong_ctrl.
interface pkt_pingpong_ctrl_if #(
    parameter int LEN_W  = 8,
    parameter int FREE_W = 7
);
    logic              in_valid_in;
    logic              in_sop_in;
    logic [LEN_W-1:0]  in_length_in;
    logic              in_ready_out;
    logic              fifo1_wr_en;
    logic              fifo2_wr_en;
    logic [FREE_W-1:0] fifo1_free_in;
    logic [FREE_W-1:0] fifo2_free_in;
    logic              fifo1_rd_en_in;
    logic              fifo2_rd_en_in;
    logic              cut_1to2_out;
    logic              cut_2to1_out;

    // Controller side
    modport slave (
        input  in_valid_in, in_sop_in, in_length_in,
        input  fifo1_free_in, fifo2_free_in,
        input  fifo1_rd_en_in, fifo2_rd_en_in,
        output in_ready_out, fifo1_wr_en, fifo2_wr_en,
        output cut_1to2_out, cut_2to1_out
    );

    // Packet source / FIFO / read sequencer side
    modport master (
        output in_valid_in, in_sop_in, in_length_in,
        output fifo1_free_in, fifo2_free_in,
        output fifo1_rd_en_in, fifo2_rd_en_in,
        input  in_ready_out, fifo1_wr_en, fifo2_wr_en,
        input  cut_1to2_out, cut_2to1_out
    );
endinterface

// File: rtl/pkt_pingpong_ctrl.sv
// Packet-level ping-pong controller: steers whole packets alternately into
// FIFO1/FIFO2, keeps a per-FIFO queue of committed packet lengths, follows
// the read sequencer's read strobes and issues cut strobes so the read side
// switches FIFO only at packet boundaries.
module pkt_pingpong_ctrl #(
    parameter int LEN_W      = 8,
    parameter int FREE_W     = 7,
    parameter int PKTQ_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    pkt_pingpong_ctrl_if.slave bus
);

    localparam int PTR_W = (PKTQ_DEPTH > 1) ? $clog2(PKTQ_DEPTH) : 1;
    localparam int CNT_W = $clog2(PKTQ_DEPTH + 1);
    localparam int CMP_W = (LEN_W > FREE_W) ? LEN_W : FREE_W;

    localparam logic SIDE_F1 = 1'b0;
    localparam logic SIDE_F2 = 1'b1;

    typedef enum logic {W_IDLE, W_PKT} wr_state_t;

    // Write side
    wr_state_t        wr_state, wr_state_nxt;
    logic             wr_tgt;
    logic [LEN_W-1:0] wr_rem;
    logic [LEN_W-1:0] wr_len;

    // Read side
    logic             rd_side;
    logic             drained;
    logic [LEN_W-1:0] rd_rem;

    // Per-FIFO committed-length queues, index 0 = FIFO1, 1 = FIFO2
    logic [LEN_W-1:0] q_mem [2][PKTQ_DEPTH];
    logic [PTR_W-1:0] q_wp  [2];
    logic [PTR_W-1:0] q_rp  [2];
    logic [CNT_W-1:0] q_cnt [2];
    logic [1:0]       q_empty, q_full, q_push, q_pop;

    // Combinational helpers
    logic             ready_raw, accept, len_zero, wr_word, start_pkt, commit;
    logic [LEN_W-1:0] commit_len;
    logic [CMP_W-1:0] free_tgt;
    logic             cut_12, cut_21, cut_any, eff_side, rd_hit, pop;
    logic [LEN_W-1:0] pop_len;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(PKTQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Queue occupancy flags and admission inputs for the current write target
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so
        // no path leaves it unassigned and no latch is inferred.
        q_empty = '0;
        q_full  = '0;
        for (int i = 0; i < 2; i++) begin
            q_empty[i] = (q_cnt[i] == '0);
            q_full[i]  = (q_cnt[i] == CNT_W'(PKTQ_DEPTH));
        end
        free_tgt = (wr_tgt == SIDE_F2) ? CMP_W'(bus.fifo2_free_in)
                                       : CMP_W'(bus.fifo1_free_in);
        len_zero = (bus.in_length_in == '0);
    end

    // Write FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) wr_state <= W_IDLE;
        else        wr_state <= wr_state_nxt;
    end

    // Write FSM next-state: enter W_PKT on a multi-word sop, leave on last word
    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            W_IDLE: if (start_pkt && bus.in_length_in != LEN_W'(1)) wr_state_nxt = W_PKT;
            W_PKT:  if (accept && wr_rem == LEN_W'(1))              wr_state_nxt = W_IDLE;
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    // Write FSM outputs: admission, FIFO write strobes and packet commit
    always_comb begin
        ready_raw  = 1'b0;
        commit     = 1'b0;
        commit_len = wr_len;
        case (wr_state)
            W_IDLE: begin
                // Only a sop with a nonzero length must fit; anything else is
                // consumed and dropped.
                if (bus.in_sop_in && !len_zero)
                    ready_raw = (free_tgt >= CMP_W'(bus.in_length_in)) && !q_full[wr_tgt];
                else
                    ready_raw = 1'b1;
            end
            W_PKT:   ready_raw = 1'b1;
            default: ready_raw = 1'b0;
        endcase

        // Outputs are forced low while reset is asserted, even mid-packet.
        accept    = rst_n && ready_raw && bus.in_valid_in;
        start_pkt = accept && (wr_state == W_IDLE) && bus.in_sop_in && !len_zero;
        wr_word   = start_pkt || (accept && wr_state == W_PKT);

        if (start_pkt && bus.in_length_in == LEN_W'(1)) begin
            commit     = 1'b1;
            commit_len = bus.in_length_in;
        end else if (accept && wr_state == W_PKT && wr_rem == LEN_W'(1)) begin
            commit     = 1'b1;
            commit_len = wr_len;
        end

        q_push = '0;
        if (commit) q_push[wr_tgt] = 1'b1;

        bus.in_ready_out = rst_n && ready_raw;
        bus.fifo1_wr_en  = wr_word && (wr_tgt == SIDE_F1);
        bus.fifo2_wr_en  = wr_word && (wr_tgt == SIDE_F2);
    end

    // Write datapath: remaining-word count, packet length, target toggle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_tgt <= SIDE_F1;
            wr_rem <= '0;
            wr_len <= '0;
        end else begin
            if (start_pkt) begin
                wr_rem <= bus.in_length_in - 1'b1;
                wr_len <= bus.in_length_in;
            end else if (accept && wr_state == W_PKT) begin
                wr_rem <= wr_rem - 1'b1;
            end
            if (commit) wr_tgt <= ~wr_tgt;
        end
    end

    // Read side decode: cut strobes and which FIFO a read strobe belongs to
    always_comb begin
        cut_12  = drained && (rd_side == SIDE_F1) && !q_empty[1];
        cut_21  = drained && (rd_side == SIDE_F2) && !q_empty[0];
        cut_any = cut_12 || cut_21;

        // In the cut cycle the read sequencer is already on the new side.
        eff_side = cut_any ? ~rd_side : rd_side;
        rd_hit   = (eff_side == SIDE_F2) ? bus.fifo2_rd_en_in : bus.fifo1_rd_en_in;
        pop      = rd_hit && (rd_rem == '0) && !q_empty[eff_side];
        pop_len  = q_mem[eff_side][q_rp[eff_side]];

        q_pop = '0;
        if (pop) q_pop[eff_side] = 1'b1;

        bus.cut_1to2_out = rst_n && cut_12;
        bus.cut_2to1_out = rst_n && cut_21;
    end

    // Read tracking: active side, words left in the current packet, drained flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_side <= SIDE_F1;
            rd_rem  <= '0;
            drained <= 1'b0;
        end else begin
            if (cut_any) begin
                rd_side <= ~rd_side;
                drained <= 1'b0;
            end
            // NOTE: with non-blocking assignments the last one in program order
            // wins, so a single-word pop in the cut cycle re-sets drained.
            if (pop) begin
                rd_rem  <= pop_len - 1'b1;
                drained <= (pop_len == LEN_W'(1));
            end else if (rd_hit && rd_rem != '0) begin
                rd_rem <= rd_rem - 1'b1;
                if (rd_rem == LEN_W'(1)) drained <= 1'b1;
            end
        end
    end

    // Length-queue pointers and counts; a push and pop together keep the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                q_wp[i]  <= '0;
                q_rp[i]  <= '0;
                q_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (q_push[i]) q_wp[i] <= ptr_inc(q_wp[i]);
                if (q_pop[i])  q_rp[i] <= ptr_inc(q_rp[i]);
                case ({q_push[i], q_pop[i]})
                    2'b10:   q_cnt[i] <= q_cnt[i] + 1'b1;
                    2'b01:   q_cnt[i] <= q_cnt[i] - 1'b1;
                    default: q_cnt[i] <= q_cnt[i];
                endcase
            end
        end
    end

    // Length-queue storage
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the reset pointers and counts guarantee
        // no entry is read before it has been written.
        for (int i = 0; i < 2; i++) begin
            if (q_push[i]) q_mem[i][q_wp[i]] <= commit_len;
        end
    end

endmodule

// File: tb/tb_pkt_pingpong_ctrl.sv
// Directed bench for pkt_pingpong_ctrl. Each stimulus cycle pushes the
// expected {fifo1_wr_en, fifo2_wr_en, cut_1to2_out, cut_2to1_out} vector,
// tagged with its cycle number, into a scoreboard queue; an independent
// monitor pops and compares on the falling edge.
module tb_pkt_pingpong_ctrl;

    localparam int LEN_W  = 8;
    localparam int FREE_W = 7;

    localparam logic [3:0] E_0   = 4'b0000;
    localparam logic [3:0] E_W1  = 4'b1000;
    localparam logic [3:0] E_W2  = 4'b0100;
    localparam logic [3:0] E_C12 = 4'b0010;
    localparam logic [3:0] E_C21 = 4'b0001;

    typedef struct {
        int         cyc;
        logic [3:0] vec;
        string      tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc_cnt = 0;
    int   n_cmp   = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    pkt_pingpong_ctrl_if #(.LEN_W(LEN_W), .FREE_W(FREE_W)) bus ();

    pkt_pingpong_ctrl #(.LEN_W(LEN_W), .FREE_W(FREE_W), .PKTQ_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every scheduled cycle, flag any unscheduled activity
    always @(negedge clk) begin
        logic [3:0] act;
        exp_t       e;
        act = {bus.fifo1_wr_en, bus.fifo2_wr_en, bus.cut_1to2_out, bus.cut_2to1_out};
        if (exp_q.size() != 0 && exp_q[0].cyc == cyc_cnt) begin
            e = exp_q.pop_front();
            check(e.tag, 32'(act), 32'(e.vec));
        end else if (act != 4'b0000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_out: got %b expected none at t=%0t", act, $time);
        end
    end

    // One cycle of stimulus; rdy < 0 means in_ready_out is not checked
    task automatic step(input string tag, input logic v, input logic s,
                        input logic [LEN_W-1:0] len, input logic r1, input logic r2,
                        input logic [3:0] ev, input int rdy);
        bus.in_valid_in    = v;
        bus.in_sop_in      = s;
        bus.in_length_in   = len;
        bus.fifo1_rd_en_in = r1;
        bus.fifo2_rd_en_in = r2;
        exp_q.push_back('{cyc: cyc_cnt, vec: ev, tag: tag});
        @(negedge clk);
        if (rdy >= 0) check({tag, "_ready"}, 32'(bus.in_ready_out), 32'(rdy));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic [3:0] ev);
        step(tag, 1'b0, 1'b0, '0, 1'b0, 1'b0, ev, -1);
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_ready"}, 32'(bus.in_ready_out), 32'd0);
        check({tag, "_wr1"},   32'(bus.fifo1_wr_en),  32'd0);
        check({tag, "_wr2"},   32'(bus.fifo2_wr_en),  32'd0);
        check({tag, "_c12"},   32'(bus.cut_1to2_out), 32'd0);
        check({tag, "_c21"},   32'(bus.cut_2to1_out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n              = 1'b0;
        bus.in_valid_in    = 1'b0;
        bus.in_sop_in      = 1'b0;
        bus.in_length_in   = '0;
        bus.fifo1_rd_en_in = 1'b0;
        bus.fifo2_rd_en_in = 1'b0;
        bus.fifo1_free_in  = 7'd100;
        bus.fifo2_free_in  = 7'd100;

        // Reset state: an admissible sop during reset must see all outputs low
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid_in  = 1'b1;
        bus.in_sop_in    = 1'b1;
        bus.in_length_in = 8'd3;
        @(negedge clk);
        check_all_low("reset");
        @(posedge clk);
        #1;
        bus.in_valid_in = 1'b0;
        bus.in_sop_in   = 1'b0;
        rst_n           = 1'b1;

        // Basic ping-pong: len 3 -> FIFO1, len 2 -> FIFO2, drain with cuts
        step("t1_p1w1", 1, 1, 8'd3, 0, 0, E_W1, 1);
        step("t1_p1w2", 1, 0, 8'd0, 0, 0, E_W1, 1);
        step("t1_p1w3", 1, 0, 8'd0, 0, 0, E_W1, 1);
        step("t1_p2w1", 1, 1, 8'd2, 0, 0, E_W2, 1);
        step("t1_p2w2", 1, 0, 8'd0, 0, 0, E_W2, 1);
        step("t1_rd1a", 0, 0, 8'd0, 1, 0, E_0, -1);
        step("t1_rd1b", 0, 0, 8'd0, 1, 0, E_0, -1);
        step("t1_rd1c", 0, 0, 8'd0, 1, 0, E_0, -1);
        step("t1_cut12", 0, 0, 8'd0, 0, 1, E_C12, -1);
        step("t1_rd2b", 0, 0, 8'd0, 0, 1, E_0, -1);
        for (int i = 0; i < 3; i++) idle("t1_nocut", E_0);
        step("t1_p3", 1, 1, 8'd1, 0, 0, E_W1, 1);
        idle("t1_cut21", E_C21);
        step("t1_rd1p3", 0, 0, 8'd0, 1, 0, E_0, -1);

        // Zero-length sop and stray word are consumed without writes or toggle
        step("t5_len0", 1, 1, 8'd0, 0, 0, E_0, 1);
        step("t5_stray", 1, 0, 8'd5, 0, 0, E_0, 1);
        step("t5_p4", 1, 1, 8'd1, 0, 0, E_W2, 1);
        step("t5_cut12", 0, 0, 8'd0, 0, 1, E_C12, -1);
        idle("t5_nocut", E_0);

        // Insufficient free space stalls the sop until free >= length
        bus.fifo1_free_in = 7'd2;
        for (int i = 0; i < 3; i++) step("t2_stall", 1, 1, 8'd5, 0, 0, E_0, 0);
        bus.fifo1_free_in = 7'd5;
        step("t2_w1", 1, 1, 8'd5, 0, 0, E_W1, 1);
        for (int i = 0; i < 4; i++) step("t2_wn", 1, 0, 8'd0, 0, 0, E_W1, 1);
        bus.fifo1_free_in = 7'd100;
        idle("t2_cut21", E_C21);
        for (int i = 0; i < 5; i++) step("t2_rd1", 0, 0, 8'd0, 1, 0, E_0, -1);
        idle("t2_nocut", E_0);

        // FIFO1 drained while FIFO2 packet is mid-write: cut waits for commit
        step("t3_w1", 1, 1, 8'd4, 0, 0, E_W2, 1);
        step("t3_w2", 1, 0, 8'd0, 0, 0, E_W2, 1);
        idle("t3_hold", E_0);
        idle("t3_hold", E_0);
        step("t3_w3", 1, 0, 8'd0, 0, 0, E_W2, 1);
        step("t3_w4", 1, 0, 8'd0, 0, 0, E_W2, 1);
        step("t3_cut12", 0, 0, 8'd0, 0, 1, E_C12, -1);
        for (int i = 0; i < 3; i++) step("t3_rd2", 0, 0, 8'd0, 0, 1, E_0, -1);
        idle("t3_nocut", E_0);

        // Fill both length queues with single-word packets; fifth FIFO1 sop stalls
        step("t4_c1", 1, 1, 8'd1, 0, 0, E_W1, 1);
        step("t4_c2", 1, 1, 8'd1, 0, 0, E_W2 | E_C21, 1);
        for (int k = 0; k < 6; k++)
            step("t4_fill", 1, 1, 8'd1, 0, 0, (k % 2 == 0) ? E_W1 : E_W2, 1);
        step("t4_full", 1, 1, 8'd1, 0, 0, E_0, 0);
        step("t4_full", 1, 1, 8'd1, 0, 0, E_0, 0);
        step("t4_pop1", 1, 1, 8'd1, 1, 0, E_0, 0);
        step("t4_release", 1, 1, 8'd1, 0, 0, E_W1 | E_C12, 1);
        step("t4_d1", 0, 0, 8'd0, 0, 1, E_0, -1);
        for (int k = 0; k < 7; k++) begin
            if (k % 2 == 0) step("t4_d_c21", 0, 0, 8'd0, 1, 0, E_C21, -1);
            else            step("t4_d_c12", 0, 0, 8'd0, 0, 1, E_C12, -1);
        end
        idle("t4_nocut", E_0);

        // Commit to FIFO2 in the same cycle as a FIFO2 pop keeps its count
        step("t7_a", 1, 1, 8'd1, 0, 0, E_W2, 1);
        step("t7_b", 1, 1, 8'd1, 0, 0, E_W1 | E_C12, 1);
        step("t7_c1", 1, 1, 8'd2, 0, 0, E_W2, 1);
        step("t7_c2pop", 1, 0, 8'd0, 0, 1, E_W2, 1);
        step("t7_cut21", 0, 0, 8'd0, 1, 0, E_C21, -1);
        step("t7_cut12", 0, 0, 8'd0, 0, 1, E_C12, -1);
        step("t7_rd2", 0, 0, 8'd0, 0, 1, E_0, -1);
        idle("t7_nocut", E_0);

        // Asynchronous reset in the middle of a 6-word packet
        step("t6_w1", 1, 1, 8'd6, 0, 0, E_W1, 1);
        step("t6_w2", 1, 0, 8'd0, 0, 0, E_W1, 1);
        bus.in_valid_in = 1'b1;
        bus.in_sop_in   = 1'b0;
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        check_all_low("t6_rst");
        @(posedge clk);
        #1;
        bus.in_valid_in = 1'b0;
        rst_n           = 1'b1;
        step("t6_p1w1", 1, 1, 8'd2, 0, 0, E_W1, 1);
        step("t6_p1w2", 1, 0, 8'd0, 0, 0, E_W1, 1);
        step("t6_rd1a", 0, 0, 8'd0, 1, 0, E_0, -1);
        step("t6_rd1b", 0, 0, 8'd0, 1, 0, E_0, -1);
        step("t6_p2", 1, 1, 8'd1, 0, 0, E_W2, 1);
        idle("t6_cut12", E_C12);
        idle("t6_nocut", E_0);

        idle("tail", E_0);
        check("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
